// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, primary
// opcode values and the machine word width.
package mips_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/next_pc_gen.sv
// Next-PC selection for the execute window: jump beats a taken branch,
// which beats sequential flow. Purely combinational; all adds wrap mod 2^32.
module next_pc_gen
  import mips_pkg::*;
(
  input  logic [WORD-1:0] pc_plus4,
  input  logic [WORD-1:0] instr,
  input  logic            jump,
  input  logic            branch,
  input  logic            zero,
  output logic [WORD-1:0] next_pc
);

  logic [WORD-1:0] branch_offset;
  logic [WORD-1:0] branch_target;
  logic [WORD-1:0] jump_target;
  // The opcode field plays no part in target arithmetic; the decoder
  // already folded it into jump/branch.
  logic            unused_opcode_bits;

  assign unused_opcode_bits = ^instr[31:26];

  // Word offset, sign-extended and scaled to bytes.
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  // Jump stays inside the 256 MB region of the delay-slot address.
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Priority select of the next program counter.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns PC, instruction register and the retired
// counter, fetches through a req/ready port and holds each instruction for
// an execute window of at least one cycle.
//
// Memory handshake: imem_req is high for the whole FETCH state with
// imem_addr held at pc; the transfer happens on the first rising edge where
// imem_req and imem_ready are both high, and imem_ready is ignored at any
// other time. imem_ready may depend combinationally on imem_req/imem_addr;
// nothing here depends combinationally on imem_ready.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [WORD-1:0] imem_rdata,
  input  logic            stall,
  input  logic            jump,
  input  logic            branch,
  input  logic            zero,
  output logic [WORD-1:0] instr,
  output logic [5:0]      opcode,
  output logic            instr_valid,
  output logic [WORD-1:0] pc,
  output logic [WORD-1:0] pc_plus4,
  output logic [WORD-1:0] retired
);

  fetch_state_t    state;
  logic [WORD-1:0] next_pc;

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign pc_plus4  = pc + 32'd4;

  next_pc_gen u_next_pc_gen (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .jump     (jump),
    .branch   (branch),
    .zero     (zero),
    .next_pc  (next_pc)
  );

  // Fetch FSM with PC, IR, retire counter and registered req/valid flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      retired     <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state       <= FETCH;
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
        end
        FETCH: begin
          // stall has no effect here; only the memory decides.
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          // instr is held for as long as the datapath stalls.
          if (!stall) begin
            pc          <= next_pc;
            retired     <= retired + 32'd1;
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
